audio_pwm_player: RTL

Downstream consumer of the Pico serial receiver. Accepts 16-bit signed audio samples on a single-cycle strobe and buffers them in a small FIFO. Pops one sample per fixed sample-rate tick and converts it to a glitch-free PWM output that drives the board's audio low-pass filter. Sticky flags report buffer overflow and underflow to the control logic.

---
 rtl/audio_pwm_player.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/audio_pwm_player.sv
// audio_pwm_player
//   Buffers 16-bit signed audio samples in a small FIFO, pops one sample per
//   sample-rate tick and renders it as a registered PWM bit stream for the
//   board's audio low-pass filter. Sticky flags report dropped samples
//   (overflow) and starved ticks (underflow).
//
//   Optional build macro: AUDIO_PWM_DITHER_EN
//     When defined, first-order error feedback carries the truncated
//     residual between samples. When undefined, the duty is plain truncation.
//
// Ports
//   clk_25mhz    in   system clock
//   reset        in   asynchronous, active-high
//   sample_in    in   16-bit signed sample
//   sample_valid in   one-cycle push strobe
//   enable       in   playback enable (0 forces IDLE)
//   clear_flags  in   one-cycle pulse, clears overflow/underflow
//   pwm_out      out  registered PWM output
//   fifo_level   out  FIFO occupancy
//   overflow     out  sticky, a sample was dropped
//   underflow    out  sticky, a PLAY tick found the FIFO empty
module audio_pwm_player #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int SAMPLE_HZ  = 48_000,
   parameter int FIFO_DEPTH = 16,
   parameter int PWM_BITS   = 8
) (
   input  logic                          clk_25mhz,
   input  logic                          reset,
   input  logic [15:0]                   sample_in,
   input  logic                          sample_valid,
   input  logic                          enable,
   input  logic                          clear_flags,
   output logic                          pwm_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int TW         = $clog2(SAMPLE_DIV);
   localparam int RES        = 16 - PWM_BITS;

   localparam logic [TW-1:0]       TICK_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [AW:0]         LVL_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]         LVL_HALF  = (AW+1)'(FIFO_DEPTH / 2);
   localparam logic [AW:0]         LVL_ONE   = (AW+1)'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

   typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

   state_t                state;
   logic [TW-1:0]         tick_cnt;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [PWM_BITS-1:0]   pend_duty;
   logic [PWM_BITS-1:0]   active_duty;
   logic [15:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   logic                  tick, play_tick, pop, push, drop, starve;
   logic                  fifo_empty, fifo_full;
   logic [15:0]           offs;
   logic [PWM_BITS-1:0]   trunc;
   logic [PWM_BITS-1:0]   pop_duty;

   assign tick       = (state != IDLE) && (tick_cnt == TICK_LAST);
   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LVL_FULL);
   assign play_tick  = enable && (state == PLAY) && tick;
   assign pop        = play_tick && !fifo_empty;
   assign starve     = play_tick && fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push       = sample_valid && (!fifo_full || pop);
   assign drop       = sample_valid && !push;

   // Signed -> offset binary, keep the top PWM_BITS bits.
   assign offs  = mem[rd_ptr] ^ 16'h8000;
   assign trunc = offs[15:RES];

`ifdef AUDIO_PWM_DITHER_EN
   logic [RES-1:0] acc;
   logic [RES:0]   acc_sum;

   assign acc_sum  = {1'b0, acc} + {1'b0, offs[RES-1:0]};
   // The residual carry bumps the duty by one LSB, never wrapping past max.
   assign pop_duty = (acc_sum[RES] && (trunc != DUTY_MAX)) ? trunc + PWM_BITS'(1) : trunc;

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (!enable || state != PLAY || starve)
         acc <= '0;
      else if (pop)
         acc <= acc_sum[RES-1:0];
   end
`else
   logic unused_lsb;
   assign unused_lsb = ^offs[RES-1:0];
   assign pop_duty   = trunc;
`endif

   // Sample storage needs no reset; emptiness is carried by the pointers.
   always_ff @(posedge clk_25mhz) begin
      if (push)
         mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
         // A new event outranks a clear in the same cycle.
         overflow  <= drop   | (overflow  & ~clear_flags);
         underflow <= starve | (underflow & ~clear_flags);
      end
   end

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         pwm_cnt     <= '0;
         pend_duty   <= '0;
         active_duty <= '0;
         pwm_out     <= 1'b0;
      end else begin
         pwm_out <= (state != IDLE) && (pwm_cnt < active_duty);

         if (!enable) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            pwm_cnt     <= '0;
            pend_duty   <= '0;
            active_duty <= '0;
         end else begin
            if (state == IDLE) begin
               tick_cnt <= '0;
               pwm_cnt  <= '0;
            end else begin
               tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
               pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
               // Duty changes only at a period boundary, so no period is cut short.
               if (pwm_cnt == DUTY_MAX)
                  active_duty <= pend_duty;
            end

            case (state)
               IDLE: begin
                  state       <= PRIME;
                  pend_duty   <= DUTY_MID;
                  // First PRIME period starts at mid-scale rather than silence.
                  active_duty <= DUTY_MID;
               end
               PRIME: begin
                  pend_duty <= DUTY_MID;
                  if (fifo_level >= LVL_HALF)
                     state <= PLAY;
               end
               PLAY: begin
                  if (pop) begin
                     pend_duty <= pop_duty;
                  end else if (starve) begin
                     pend_duty <= DUTY_MID;
                     state     <= PRIME;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
